button_deb_multi: RTL
=====================

Name: button_deb_multi

Overview:
Parametrised successor of the single-button debouncer. Debounces NB_BUTTONS independent asynchronous button inputs against one shared 1 ms timebase and outputs per channel: debounced level, one-cycle press/release pulses and a one-shot long-press pulse. Sits between board pins and user-interface logic; one instance replaces N single-channel debouncers.

Parameters:
CLK_FREQ, 95_000, clock frequency in kHz (clock cycles per ms); must be >= 2
DEBOUNCE_PER_MS, 20, stability time in ms required before a level change is accepted; >= 1
LONG_PRESS_MS, 1000, ms of continuous debounced press before button_long fires; > DEBOUNCE_PER_MS
NB_BUTTONS, 4, number of independent channels; >= 1
ACTIVE_LOW, 0, 1 = pressed when pin is 0 (input inverted before synchroniser)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
button_in  input  NB_BUTTONS  raw asynchronous button pins
button_valid  output  NB_BUTTONS  debounced level, 1 = pressed (after polarity)
button_press  output  NB_BUTTONS  1-cycle pulse on accepted 0->1 of button_valid
button_release  output  NB_BUTTONS  1-cycle pulse on accepted 1->0 of button_valid
button_long  output  NB_BUTTONS  1-cycle pulse once per press after LONG_PRESS_MS held
ms_tick  output  1  shared 1 ms strobe, one cycle high every CLK_FREQ cycles

Behaviour:
- Reset (async assert, sync release in effect): prescaler=0, all synchroniser FFs, debounce/long counters, long_done flags and all outputs = 0. Stable state = not pressed regardless of pin level.
- Prescaler: counts 0..CLK_FREQ-1, wraps to 0; ms_tick=1 on the cycle count==CLK_FREQ-1. First tick CLK_FREQ cycles after reset release.
- Per channel input path: p = button_in ^ ACTIVE_LOW, then 2-FF synchroniser -> s. No combinational path from button_in to outputs.
- Debounce counter dcnt (width clog2(DEBOUNCE_PER_MS+1)), per channel, every cycle:
  - s == button_valid: dcnt <= 0 (any bounce back restarts timing).
  - s != button_valid and ms_tick and dcnt == DEBOUNCE_PER_MS-1: button_valid <= s, dcnt <= 0.
  - s != button_valid and ms_tick otherwise: dcnt <= dcnt+1.
  - Acceptance time after a clean edge: between DEBOUNCE_PER_MS-1 and DEBOUNCE_PER_MS ms plus 2-3 cycles (tick quantisation); any glitch shorter than DEBOUNCE_PER_MS-1 ms is always rejected.
- button_press/button_release: registered, asserted the cycle after button_valid changes, exactly 1 cycle; never both in the same cycle on one channel.
- Long press, per channel counter lcnt (width clog2(LONG_PRESS_MS+1)) + long_done flag:
  - button_valid==0: lcnt<=0, long_done<=0.
  - button_valid==1, !long_done, ms_tick: lcnt<=lcnt+1; when lcnt reaches LONG_PRESS_MS-1 on a tick: button_long pulses 1 cycle, long_done<=1, lcnt holds.
  - No repeat until release; release before threshold produces no button_long.
- Channels fully independent; simultaneous events on several channels produce simultaneous pulses.
- Reset mid-operation: all state cleared immediately; a button held through reset release needs a full new debounce period and generates a fresh button_press.
- No counter may wrap: dcnt bounded by DEBOUNCE_PER_MS-1, lcnt saturates.

Test Plan:
(Bench params CLK_FREQ=10, DEBOUNCE_PER_MS=4, LONG_PRESS_MS=20, NB_BUTTONS=4, clk 10 ns => 1 ms tick = 100 ns.)
1 Reset: rst=1 with button_in=4'hF, release -> all outputs 0; ms_tick every 10 cycles, first 10 cycles after release; valid rises 3-4 ticks later with one press pulse per channel.
2 Bounce reject: ch0 pulses 1 for 1,2,2.5 ticks separated by 1-tick 0 gaps -> button_valid[0] stays 0, no press pulse; then held 1 -> button_valid[0]=1 within 3-4 ticks + 3 cycles, button_press[0] exactly 1 cycle.
3 Release bounce: ch0 pressed, input toggles 0/1 with 2-tick periods for 12 ticks, then 0 -> single button_release[0] after final 0 stable 3-4 ticks, none earlier.
4 Long press: hold ch1 25 ms -> button_long[1] one cycle ~20 ticks after button_valid[1] rises, once only; release at 15 ms on second press -> no button_long.
5 Independence/simultaneous: ch2 and ch3 pressed same cycle, ch0 bouncing -> press[2],press[3] same cycle, ch0 unaffected.
6 ACTIVE_LOW=1 instance: pins idle 1 -> valid 0; pin to 0 held 5 ms -> button_valid=1, press pulse; rst mid-press -> outputs clear at once, press re-reported after debounce.

Source files
------------

// File: rtl/button_deb_multi.sv
// Multi-channel button debouncer with one shared 1 ms timebase.
// Per channel it outputs the debounced level, press/release pulses and a one-shot long-press pulse.
module button_deb_multi #(
  parameter int CLK_FREQ        = 95_000,
  parameter int DEBOUNCE_PER_MS = 20,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int NB_BUTTONS      = 4,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_BUTTONS-1:0] button_in,
  output logic [NB_BUTTONS-1:0] button_valid,
  output logic [NB_BUTTONS-1:0] button_press,
  output logic [NB_BUTTONS-1:0] button_release,
  output logic [NB_BUTTONS-1:0] button_long,
  output logic                  ms_tick
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int DW = $clog2(DEBOUNCE_PER_MS + 1);
  localparam int LW = $clog2(LONG_PRESS_MS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DCNT_MAX  = DW'(DEBOUNCE_PER_MS - 1);
  localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_PRESS_MS - 1);
  localparam logic [NB_BUTTONS-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]         r_presc;
  logic                  w_tick;
  logic [NB_BUTTONS-1:0] r_sync1;
  logic [NB_BUTTONS-1:0] r_sync2;
  logic [NB_BUTTONS-1:0] r_valid;
  logic [NB_BUTTONS-1:0] r_validDly;
  logic [NB_BUTTONS-1:0] r_press;
  logic [NB_BUTTONS-1:0] r_release;
  logic [NB_BUTTONS-1:0] r_long;
  logic [NB_BUTTONS-1:0] r_longDone;
  logic [DW-1:0]         r_dcnt [NB_BUTTONS];
  logic [LW-1:0]         r_lcnt [NB_BUTTONS];

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Any cycle where the synchronised level matches the accepted level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_valid    <= '0;
      r_validDly <= '0;
      r_press    <= '0;
      r_release  <= '0;
      for (int i = 0; i < NB_BUTTONS; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_sync1    <= button_in ^ POL;
      r_sync2    <= r_sync1;
      r_validDly <= r_valid;
      r_press    <= r_valid & ~r_validDly;
      r_release  <= ~r_valid & r_validDly;
      for (int i = 0; i < NB_BUTTONS; i++) begin
        if (r_sync2[i] == r_valid[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_tick) begin
          if (r_dcnt[i] == DCNT_MAX) begin
            r_valid[i] <= r_sync2[i];
            r_dcnt[i]  <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DW'(1);
          end
        end
      end
    end
  end

  // Once fired, the long-press counter freezes until the button is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_long     <= '0;
      r_longDone <= '0;
      for (int i = 0; i < NB_BUTTONS; i++) begin
        r_lcnt[i] <= '0;
      end
    end else begin
      r_long <= '0;
      for (int i = 0; i < NB_BUTTONS; i++) begin
        if (!r_valid[i]) begin
          r_lcnt[i]     <= '0;
          r_longDone[i] <= 1'b0;
        end else if (!r_longDone[i] && w_tick) begin
          if (r_lcnt[i] == LCNT_MAX) begin
            r_long[i]     <= 1'b1;
            r_longDone[i] <= 1'b1;
          end else begin
            r_lcnt[i] <= r_lcnt[i] + LW'(1);
          end
        end
      end
    end
  end

  assign button_valid   = r_valid;
  assign button_press   = r_press;
  assign button_release = r_release;
  assign button_long    = r_long;
  assign ms_tick        = w_tick;

endmodule
